// File: rtl/ifm_row_loader_pkg.sv
// ifm_row_loader_pkg
//   Shared definitions for the IFM row loader. The package holds:
//     - the load FSM state encoding
//     - the default outstanding-read limit
//     - the width of the outstanding-read counter
//     - a helper that tells whether read data may be accepted in a given state
`timescale 1ns/1ps
package ifm_row_loader_pkg;

  typedef enum logic [2:0] {
    IFM_LD_IDLE  = 3'd0,
    IFM_LD_SETUP = 3'd1,
    IFM_LD_ISSUE = 3'd2,
    IFM_LD_DRAIN = 3'd3,
    IFM_LD_DONE  = 3'd4
  } ifm_ld_state_e;

  // Default cap on reads in flight. The cap must stay at 255 or below, so that
  // the outstanding-read counter fits in 8 bits.
  localparam int IFM_MAX_OUTS = 8;
  localparam int W_OUTS       = 8;

  // Read data belongs to the current row only while the FSM is issuing or
  // draining.
  function automatic logic ifm_ld_accepts_data(input ifm_ld_state_e s);
    return (s == IFM_LD_ISSUE) || (s == IFM_LD_DRAIN);
  endfunction

endpackage

// File: rtl/ifm_row_loader_addr_gen.sv
// ifm_row_addr_gen
//   Issue side of the row loader. This block:
//     - computes the start address of a row: base + row*L
//     - walks the word index k from 0 to L-1
//     - drives the read-address handshake
//     - limits the number of reads in flight to MAX_OUTS
//
//   Ports:
//     clk, rst        clock and synchronous active-high reset
//     i_start         pulse in SETUP. It loads the start address and clears k and outs.
//     i_issue_en      high while the FSM is in ISSUE
//     i_row, i_len    latched row number and row length L
//     i_base          word address of row 0
//     i_beat          an accepted read-data beat. It decrements outs.
//     o_rd_req        read-address request
//     o_rd_addr       read address
//     i_rd_ready      ready input of the read-address handshake
//     o_last_issue    high on the handshake for word L-1
//     o_outs          number of reads currently in flight
`timescale 1ns/1ps
module ifm_row_addr_gen
  import ifm_row_loader_pkg::*;
#(
  parameter int W_SIZE    = 8,
  parameter int W_CHANNEL = 8,
  parameter int W_ADDR    = 32,
  parameter int MAX_OUTS  = IFM_MAX_OUTS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_start,
  input  logic                          i_issue_en,
  input  logic [W_SIZE-1:0]             i_row,
  input  logic [W_SIZE+W_CHANNEL-1:0]   i_len,
  input  logic [W_ADDR-1:0]             i_base,
  input  logic                          i_beat,
  output logic                          o_rd_req,
  output logic [W_ADDR-1:0]             o_rd_addr,
  input  logic                          i_rd_ready,
  output logic                          o_last_issue,
  output logic [W_OUTS-1:0]             o_outs
);

  localparam int W_LEN = W_SIZE + W_CHANNEL;
  localparam logic [W_OUTS-1:0] MAX_OUTS_V = W_OUTS'(MAX_OUTS);

  logic [W_ADDR-1:0] addr_q, addr_d;
  logic [W_LEN-1:0]  k_q, k_d;
  logic [W_OUTS-1:0] outs_q, outs_d;
  logic [W_ADDR-1:0] start_addr;
  logic              fire;

  // The product is registered in SETUP. This keeps the multiplier off the
  // path that feeds the issue logic.
  assign start_addr   = i_base + (W_ADDR'(i_row) * W_ADDR'(i_len));

  assign o_rd_req     = i_issue_en && (outs_q < MAX_OUTS_V);
  assign fire         = o_rd_req && i_rd_ready;
  assign o_last_issue = fire && (k_q == (i_len - W_LEN'(1)));
  assign o_rd_addr    = addr_q;
  assign o_outs       = outs_q;

  always_comb begin
    addr_d = addr_q;
    k_d    = k_q;
    outs_d = outs_q;
    if (i_start) begin
      addr_d = start_addr;
      k_d    = '0;
      outs_d = '0;
    end else begin
      if (fire) begin
        addr_d = addr_q + W_ADDR'(1);
        k_d    = k_q + W_LEN'(1);
      end
      // An issue and a beat in the same cycle cancel out.
      case ({fire, i_beat})
        2'b10:   outs_d = outs_q + W_OUTS'(1);
        2'b01:   outs_d = outs_q - W_OUTS'(1);
        default: outs_d = outs_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      k_q    <= '0;
      outs_q <= '0;
    end else begin
      addr_q <= addr_d;
      k_q    <= k_d;
      outs_q <= outs_d;
    end
  end

endmodule

// File: rtl/ifm_row_loader.sv
// ifm_row_loader
//   Responder for the IFM row-load handshake. It accepts a request for one row
//   and reads that row's L = channel*width words through a valid/ready read
//   port. Each returned word is written into ring row buffer (row mod
//   IFM_BUF_CNT) at index k = c*width + x. After the last write, o_req_done
//   pulses for one cycle.
//
//   Ports:
//     clk, rst                      clock and synchronous active-high reset
//     q_req_load, q_req_row         load request pulse and the row to load
//     q_width, q_height, q_channel  layer geometry, held stable while busy
//     q_base_addr                   word address of row 0, channel 0, column 0
//     o_rd_req, o_rd_addr, i_rd_ready
//                                   read-address handshake
//     i_rd_data_vld, i_rd_data      in-order read data
//     o_buf_we, o_buf_sel, o_buf_addr, o_buf_wdata
//                                   registered row-buffer write port
//     o_req_done                    one-cycle pulse when the row is fully written
//     o_busy                        high from SETUP through DONE
//     o_req_err                     one-cycle pulse on a rejected request or a stray beat
`timescale 1ns/1ps
module ifm_row_loader
  import ifm_row_loader_pkg::*;
#(
  parameter int W_SIZE      = 8,
  parameter int W_CHANNEL   = 8,
  parameter int IFM_BUF_CNT = 4,
  parameter int W_IFM_BUF   = 2,
  parameter int W_ADDR      = 32,
  parameter int W_DATA      = 32,
  parameter int MAX_OUTS    = IFM_MAX_OUTS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          q_req_load,
  input  logic [W_SIZE-1:0]             q_req_row,
  input  logic [W_SIZE-1:0]             q_width,
  input  logic [W_SIZE-1:0]             q_height,
  input  logic [W_CHANNEL-1:0]          q_channel,
  input  logic [W_ADDR-1:0]             q_base_addr,
  output logic                          o_rd_req,
  output logic [W_ADDR-1:0]             o_rd_addr,
  input  logic                          i_rd_ready,
  input  logic                          i_rd_data_vld,
  input  logic [W_DATA-1:0]             i_rd_data,
  output logic                          o_buf_we,
  output logic [W_IFM_BUF-1:0]          o_buf_sel,
  output logic [W_SIZE+W_CHANNEL-1:0]   o_buf_addr,
  output logic [W_DATA-1:0]             o_buf_wdata,
  output logic                          o_req_done,
  output logic                          o_busy,
  output logic                          o_req_err
);

  localparam int W_LEN = W_SIZE + W_CHANNEL;

  ifm_ld_state_e        state_q, state_d;
  logic [W_SIZE-1:0]    row_q, row_d;
  logic [W_LEN-1:0]     recv_q, recv_d;
  logic                 we_q, we_d;
  logic [W_IFM_BUF-1:0] sel_q, sel_d;
  logic [W_LEN-1:0]     baddr_q, baddr_d;
  logic [W_DATA-1:0]    wdata_q, wdata_d;
  logic                 err_q, err_d;

  logic [W_LEN-1:0]     row_len;
  logic [W_IFM_BUF-1:0] row_sel;
  logic [W_OUTS-1:0]    outs;
  logic                 last_issue;
  logic                 beat_ok;
  logic                 req_ok;

  assign row_len = W_LEN'(q_channel) * W_LEN'(q_width);

  // When the buffer count is a power of two, the ring index is simply the low
  // row bits.
  generate
    if (IFM_BUF_CNT == (1 << W_IFM_BUF)) begin : g_sel_pow2
      assign row_sel = row_q[W_IFM_BUF-1:0];
    end else begin : g_sel_mod
      assign row_sel = W_IFM_BUF'(row_q % W_SIZE'(IFM_BUF_CNT));
    end
  endgenerate

  // A beat is accepted only if it can belong to a read that this transfer
  // issued. Otherwise it is stale or stray.
  assign beat_ok = i_rd_data_vld && ifm_ld_accepts_data(state_q) && (outs != '0);
  assign req_ok  = (state_q == IFM_LD_IDLE) && q_req_load && (q_req_row < q_height);

  ifm_row_addr_gen #(
    .W_SIZE    (W_SIZE),
    .W_CHANNEL (W_CHANNEL),
    .W_ADDR    (W_ADDR),
    .MAX_OUTS  (MAX_OUTS)
  ) u_addr_gen (
    .clk          (clk),
    .rst          (rst),
    .i_start      (state_q == IFM_LD_SETUP),
    .i_issue_en   (state_q == IFM_LD_ISSUE),
    .i_row        (row_q),
    .i_len        (row_len),
    .i_base       (q_base_addr),
    .i_beat       (beat_ok),
    .o_rd_req     (o_rd_req),
    .o_rd_addr    (o_rd_addr),
    .i_rd_ready   (i_rd_ready),
    .o_last_issue (last_issue),
    .o_outs       (outs)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    recv_d  = recv_q;
    we_d    = beat_ok;
    sel_d   = sel_q;
    baddr_d = baddr_q;
    wdata_d = wdata_q;
    err_d   = (q_req_load && !req_ok) || (i_rd_data_vld && !beat_ok);

    case (state_q)
      IFM_LD_IDLE: begin
        if (req_ok) begin
          row_d   = q_req_row;
          state_d = IFM_LD_SETUP;
        end
      end
      IFM_LD_SETUP: begin
        recv_d  = '0;
        state_d = (row_len == '0) ? IFM_LD_DONE : IFM_LD_ISSUE;
      end
      IFM_LD_ISSUE: begin
        if (last_issue) state_d = IFM_LD_DRAIN;
      end
      IFM_LD_DRAIN: begin
        if (recv_q == row_len) state_d = IFM_LD_DONE;
      end
      IFM_LD_DONE: begin
        state_d = IFM_LD_IDLE;
      end
      default: state_d = IFM_LD_IDLE;
    endcase

    if (beat_ok) begin
      recv_d  = recv_q + W_LEN'(1);
      sel_d   = row_sel;
      baddr_d = recv_q;
      wdata_d = i_rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IFM_LD_IDLE;
      row_q   <= '0;
      recv_q  <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      baddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      recv_q  <= recv_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      baddr_q <= baddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign o_buf_we    = we_q;
  assign o_buf_sel   = sel_q;
  assign o_buf_addr  = baddr_q;
  assign o_buf_wdata = wdata_q;
  assign o_req_done  = (state_q == IFM_LD_DONE);
  assign o_busy      = (state_q != IFM_LD_IDLE);
  assign o_req_err   = err_q;

endmodule
